triangle_raster_scanner: RTL and testbench

TRIANGLE_RASTER_SCANNER -- requirements
Module: triangle_raster_scanner

---
 rtl/triangle_raster_scanner_pkg.sv | 21 ++
 rtl/triangle_raster_scanner_if.sv | 40 ++++
 rtl/triangle_raster_scanner_eval.sv | 60 ++++++
 rtl/triangle_raster_scanner.sv | 157 +++++++++++++++
 tb/tb_triangle_raster_scanner.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/triangle_raster_scanner_pkg.sv
// rtl/triangle_raster_scanner_pkg.sv - shared FSM state, fixed-point width helper and ONE constant
package triangle_raster_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    function automatic int fx_width(input int int_bits, input int dec_bits);
        return int_bits + dec_bits + 1;
    endfunction

    function automatic int fx_one(input int dec_bits);
        return 1 << dec_bits;
    endfunction

    localparam int DEF_DEC_BITS = 8;
    localparam int ONE          = fx_one(DEF_DEC_BITS);

endpackage

// File: rtl/triangle_raster_scanner_if.sv
// rtl/triangle_raster_scanner_if.sv - request/pixel bundle of the raster scanner (pix_count under RASTER_PIXCOUNT_EN)
interface triangle_raster_scanner_if
    import triangle_raster_scanner_pkg::*;
#(
    parameter int EVAL_BITS = 8,
    parameter int INT_BITS  = 4,
    parameter int DEC_BITS  = 8
) ();
    localparam int W = fx_width(INT_BITS, DEC_BITS);

    logic                        start;
    logic signed [W-1:0]         x_0, y_0, x_1, y_1, x_2, y_2;
    logic [EVAL_BITS-1:0]        xmin, xmax, ymin, ymax;
    logic                        busy;
    logic                        done;
    logic                        pix_valid;
    logic                        pix_ready;
    logic [EVAL_BITS-1:0]        pix_x, pix_y;
    logic signed [W-1:0]         pix_l0, pix_l1, pix_l2;
`ifdef RASTER_PIXCOUNT_EN
    logic [2*EVAL_BITS:0]        pix_count;
`endif

    modport master (
        output start, x_0, y_0, x_1, y_1, x_2, y_2, xmin, xmax, ymin, ymax, pix_ready,
        input  busy, done, pix_valid, pix_x, pix_y, pix_l0, pix_l1, pix_l2
`ifdef RASTER_PIXCOUNT_EN
        , input pix_count
`endif
    );

    modport slave (
        input  start, x_0, y_0, x_1, y_1, x_2, y_2, xmin, xmax, ymin, ymax, pix_ready,
        output busy, done, pix_valid, pix_x, pix_y, pix_l0, pix_l1, pix_l2
`ifdef RASTER_PIXCOUNT_EN
        , output pix_count
`endif
    );

endinterface

// File: rtl/triangle_raster_scanner_eval.sv
// rtl/triangle_raster_scanner_eval.sv - combinational barycentric evaluator for one integer pixel
module triangle_raster_scanner_eval
    import triangle_raster_scanner_pkg::*;
#(
    parameter int INT_BITS  = 4,
    parameter int DEC_BITS  = 8,
    parameter int EVAL_BITS = 8,
    localparam int W        = fx_width(INT_BITS, DEC_BITS)
) (
    input  logic signed [W-1:0]  x_0_i,
    input  logic signed [W-1:0]  y_0_i,
    input  logic signed [W-1:0]  x_1_i,
    input  logic signed [W-1:0]  y_1_i,
    input  logic signed [W-1:0]  x_2_i,
    input  logic signed [W-1:0]  y_2_i,
    input  logic [EVAL_BITS-1:0] px_i,
    input  logic [EVAL_BITS-1:0] py_i,
    output logic                 inside_o,
    output logic signed [W-1:0]  l0_o,
    output logic signed [W-1:0]  l1_o,
    output logic signed [W-1:0]  l2_o
);
    localparam int PW  = EVAL_BITS + DEC_BITS + 1;
    localparam int DW  = ((PW > W) ? PW : W) + 1;
    localparam int PRW = 2 * DW + 1;
    localparam int NW  = PRW + DEC_BITS + 1;

    logic signed [DW-1:0]  pxf, pyf, ex1, ey1, ex2, ey2, dpx, dpy;
    logic signed [PRW-1:0] det, n1, n2, area, a0, a1, a2;
    logic                  flip;

    assign pxf = DW'($signed({1'b0, px_i, {DEC_BITS{1'b0}}}));
    assign pyf = DW'($signed({1'b0, py_i, {DEC_BITS{1'b0}}}));
    assign ex1 = DW'(x_1_i) - DW'(x_0_i);
    assign ey1 = DW'(y_1_i) - DW'(y_0_i);
    assign ex2 = DW'(x_2_i) - DW'(x_0_i);
    assign ey2 = DW'(y_2_i) - DW'(y_0_i);
    assign dpx = pxf - DW'(x_0_i);
    assign dpy = pyf - DW'(y_0_i);

    assign det = PRW'(ex1) * PRW'(ey2) - PRW'(ex2) * PRW'(ey1);
    assign n1  = PRW'(dpx) * PRW'(ey2) - PRW'(ex2) * PRW'(dpy);
    assign n2  = PRW'(ex1) * PRW'(dpy) - PRW'(dpx) * PRW'(ey1);

    // Fold the winding into a positive area so every test below is a plain sign check.
    assign flip = det[PRW-1];
    assign area = flip ? -det : det;
    assign a1   = flip ? -n1 : n1;
    assign a2   = flip ? -n2 : n2;
    assign a0   = area - a1 - a2;

    // Edges count as inside; the three vertices themselves (one weight equal to ONE) do not.
    assign inside_o = !a0[PRW-1] && !a1[PRW-1] && !a2[PRW-1] &&
                      (a0 < area) && (a1 < area) && (a2 < area);

    assign l1_o = W'((NW'(a1) <<< DEC_BITS) / NW'(area));
    assign l2_o = W'((NW'(a2) <<< DEC_BITS) / NW'(area));
    assign l0_o = W'(fx_one(DEC_BITS)) - l1_o - l2_o;

endmodule

// File: rtl/triangle_raster_scanner.sv
// rtl/triangle_raster_scanner.sv - scans a box row-major and streams in-triangle pixels with barycentric weights
// Optional RASTER_PIXCOUNT_EN adds an accepted-pixel counter.
module triangle_raster_scanner
    import triangle_raster_scanner_pkg::*;
#(
    parameter int EVAL_BITS = 8,
    parameter int INT_BITS  = 4,
    parameter int DEC_BITS  = 8
) (
    input logic                       clk,
    input logic                       rst,
    triangle_raster_scanner_if.slave  bus
);
    localparam int W = fx_width(INT_BITS, DEC_BITS);

    state_e                state_q;
    logic                  busy_q, done_q, pix_valid_q;
    logic [EVAL_BITS-1:0]  pix_x_q, pix_y_q;
    logic signed [W-1:0]   pix_l0_q, pix_l1_q, pix_l2_q;
    logic [EVAL_BITS-1:0]  cx_q, cy_q, cx_d, cy_d;
    logic [EVAL_BITS-1:0]  xmin_q, xmax_q, ymax_q;
    logic signed [W-1:0]   vx0_q, vy0_q, vx1_q, vy1_q, vx2_q, vy2_q;
`ifdef RASTER_PIXCOUNT_EN
    logic [2*EVAL_BITS:0]  pix_count_q;
`endif

    logic                  stall, row_end, last_pt, box_empty;
    logic                  ev_inside;
    logic signed [W-1:0]   ev_l0, ev_l1, ev_l2;

    triangle_raster_scanner_eval #(
        .INT_BITS  (INT_BITS),
        .DEC_BITS  (DEC_BITS),
        .EVAL_BITS (EVAL_BITS)
    ) u_eval (
        .x_0_i    (vx0_q),
        .y_0_i    (vy0_q),
        .x_1_i    (vx1_q),
        .y_1_i    (vy1_q),
        .x_2_i    (vx2_q),
        .y_2_i    (vy2_q),
        .px_i     (cx_q),
        .py_i     (cy_q),
        .inside_o (ev_inside),
        .l0_o     (ev_l0),
        .l1_o     (ev_l1),
        .l2_o     (ev_l2)
    );

    always_comb begin
        stall     = pix_valid_q && !bus.pix_ready;
        row_end   = (cx_q == xmax_q);
        last_pt   = row_end && (cy_q == ymax_q);
        cx_d      = row_end ? xmin_q : cx_q + 1'b1;
        cy_d      = row_end ? cy_q + 1'b1 : cy_q;
        box_empty = (bus.xmin > bus.xmax) || (bus.ymin > bus.ymax);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_l0_q    <= '0;
            pix_l1_q    <= '0;
            pix_l2_q    <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymax_q      <= '0;
            vx0_q       <= '0;
            vy0_q       <= '0;
            vx1_q       <= '0;
            vy1_q       <= '0;
            vx2_q       <= '0;
            vy2_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        vx0_q   <= bus.x_0;
                        vy0_q   <= bus.y_0;
                        vx1_q   <= bus.x_1;
                        vy1_q   <= bus.y_1;
                        vx2_q   <= bus.x_2;
                        vy2_q   <= bus.y_2;
                        xmin_q  <= bus.xmin;
                        xmax_q  <= bus.xmax;
                        ymax_q  <= bus.ymax;
                        cx_q    <= bus.xmin;
                        cy_q    <= bus.ymin;
                        busy_q  <= 1'b1;
                        state_q <= box_empty ? FLUSH : SCAN;
                    end
                end
                SCAN: begin
                    // Not stalled means the held pixel (if any) is being accepted this edge.
                    if (!stall) begin
                        pix_valid_q <= ev_inside;
                        if (ev_inside) begin
                            pix_x_q  <= cx_q;
                            pix_y_q  <= cy_q;
                            pix_l0_q <= ev_l0;
                            pix_l1_q <= ev_l1;
                            pix_l2_q <= ev_l2;
                        end
                        if (last_pt) begin
                            state_q <= FLUSH;
                        end else begin
                            cx_q <= cx_d;
                            cy_q <= cy_d;
                        end
                    end
                end
                FLUSH: begin
                    if (!pix_valid_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (bus.pix_ready) begin
                        pix_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RASTER_PIXCOUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_count_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            pix_count_q <= '0;
        end else if (pix_valid_q && bus.pix_ready) begin
            pix_count_q <= pix_count_q + 1'b1;
        end
    end

    assign bus.pix_count = pix_count_q;
`endif

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_x     = pix_x_q;
    assign bus.pix_y     = pix_y_q;
    assign bus.pix_l0    = pix_l0_q;
    assign bus.pix_l1    = pix_l1_q;
    assign bus.pix_l2    = pix_l2_q;

endmodule

// File: tb/tb_triangle_raster_scanner.sv
// tb/tb_triangle_raster_scanner.sv - directed and randomized bench for triangle_raster_scanner
module tb_triangle_raster_scanner;
    import triangle_raster_scanner_pkg::*;

    localparam int EVAL_BITS = 8;
    localparam int INT_BITS  = 4;
    localparam int DEC_BITS  = 8;
    localparam int W         = INT_BITS + DEC_BITS + 1;

    typedef struct {
        longint x0, y0, x1, y1, x2, y2;
        int     xmin, xmax, ymin, ymax;
    } tri_t;

    typedef struct {
        int     x, y;
        longint l0, l1, l2;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    triangle_raster_scanner_if #(.EVAL_BITS(EVAL_BITS), .INT_BITS(INT_BITS), .DEC_BITS(DEC_BITS)) bus ();

    triangle_raster_scanner #(.EVAL_BITS(EVAL_BITS), .INT_BITS(INT_BITS), .DEC_BITS(DEC_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    pix_t exp_q[$];
    pix_t got_q[$];
    pix_t mon_p;
    int   done_cnt  = 0;
    int   busy_cnt  = 0;
    int   valid_cnt = 0;
    int   ready_mode = 0;
    int   vtx_hits;
    int   cyc;
    tri_t t0, tb_alt, te, tw, tr;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: weights are ratios of sub-triangle areas to the full area.
    function automatic void build_model(input tri_t t);
        longint area, sa, a0, a1, a2, px, py, l1, l2;
        exp_q.delete();
        area = (t.x1 - t.x0) * (t.y2 - t.y0) - (t.x2 - t.x0) * (t.y1 - t.y0);
        sa   = (area < 0) ? -area : area;
        for (int y = t.ymin; y <= t.ymax; y++) begin
            for (int x = t.xmin; x <= t.xmax; x++) begin
                px = longint'(x) * ONE;
                py = longint'(y) * ONE;
                a1 = (px - t.x0) * (t.y2 - t.y0) - (t.x2 - t.x0) * (py - t.y0);
                a2 = (t.x1 - t.x0) * (py - t.y0) - (px - t.x0) * (t.y1 - t.y0);
                if (area < 0) begin
                    a1 = -a1;
                    a2 = -a2;
                end
                a0 = sa - a1 - a2;
                if (a0 >= 0 && a1 >= 0 && a2 >= 0 && a0 < sa && a1 < sa && a2 < sa) begin
                    l1 = (a1 * ONE) / sa;
                    l2 = (a2 * ONE) / sa;
                    exp_q.push_back('{x, y, ONE - l1 - l2, l1, l2});
                end
            end
        end
    endfunction

    task automatic drive(input tri_t t);
        bus.x_0  = W'(t.x0);
        bus.y_0  = W'(t.y0);
        bus.x_1  = W'(t.x1);
        bus.y_1  = W'(t.y1);
        bus.x_2  = W'(t.x2);
        bus.y_2  = W'(t.y2);
        bus.xmin = EVAL_BITS'(t.xmin);
        bus.xmax = EVAL_BITS'(t.xmax);
        bus.ymin = EVAL_BITS'(t.ymin);
        bus.ymax = EVAL_BITS'(t.ymax);
    endtask

    task automatic launch(input tri_t t);
        @(posedge clk); #1;
        drive(t);
        bus.start = 1'b1;
        got_q.delete();
        done_cnt  = 0;
        busy_cnt  = 0;
        valid_cnt = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done_before_timeout"}, (done_cnt != 0), 1);
        repeat (3) @(negedge clk);
        check({tag, " done_pulses"}, done_cnt, 1);
    endtask

    task automatic compare_seq(input string tag);
        check({tag, " pixel_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s px%0d x", tag, i), got_q[i].x, exp_q[i].x);
            check($sformatf("%s px%0d y", tag, i), got_q[i].y, exp_q[i].y);
            check($sformatf("%s px%0d l0", tag, i), got_q[i].l0, exp_q[i].l0);
            check($sformatf("%s px%0d l1", tag, i), got_q[i].l1, exp_q[i].l1);
            check($sformatf("%s px%0d l2", tag, i), got_q[i].l2, exp_q[i].l2);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " done"}, bus.done, 0);
        check({tag, " pix_valid"}, bus.pix_valid, 0);
        check({tag, " pix_x"}, bus.pix_x, 0);
        check({tag, " pix_y"}, bus.pix_y, 0);
        check({tag, " pix_l0"}, bus.pix_l0, 0);
        check({tag, " pix_l1"}, bus.pix_l1, 0);
        check({tag, " pix_l2"}, bus.pix_l2, 0);
    endtask

    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = ~bus.pix_ready;
                2:       bus.pix_ready = 1'($urandom_range(0, 1));
                default: bus.pix_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
                mon_p.x  = int'(bus.pix_x);
                mon_p.y  = int'(bus.pix_y);
                mon_p.l0 = longint'(bus.pix_l0);
                mon_p.l1 = longint'(bus.pix_l1);
                mon_p.l2 = longint'(bus.pix_l2);
                got_q.push_back(mon_p);
            end
            if (bus.done === 1'b1) done_cnt++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.pix_valid === 1'b1) valid_cnt++;
        end
    end

    initial begin
        bus.start = 1'b0;
        t0 = '{x0: 0, y0: 0, x1: 'h400, y1: 0, x2: 0, y2: 'h400, xmin: 0, xmax: 4, ymin: 0, ymax: 4};
        drive(t0);

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Reference triangle, always ready
        ready_mode = 0;
        build_model(t0);
        launch(t0);
        wait_done("ref");
        check("ref twelve_pixels", got_q.size(), 12);
        if (got_q.size() > 0) begin
            check("ref first_x", got_q[0].x, 1);
            check("ref first_y", got_q[0].y, 0);
        end
        vtx_hits = 0;
        foreach (got_q[i])
            if ((got_q[i].x == 0 && got_q[i].y == 0) || (got_q[i].x == 4 && got_q[i].y == 0) ||
                (got_q[i].x == 0 && got_q[i].y == 4))
                vtx_hits++;
        check("ref vertex_pixels", vtx_hits, 0);
        compare_seq("ref");
`ifdef RASTER_PIXCOUNT_EN
        check("ref pix_count", bus.pix_count, 12);
`endif

        // Same triangle with alternating ready
        ready_mode = 1;
        launch(t0);
        wait_done("toggle");
        compare_seq("toggle");
        ready_mode = 0;

        // Empty box
        te = t0;
        te.xmin = 3;
        te.xmax = 2;
        @(posedge clk); #1;
        drive(te);
        bus.start = 1'b1;
        got_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        valid_cnt = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("empty busy_after_accept", bus.busy, 1);
        check("empty done_early", bus.done, 0);
        @(posedge clk); #1;
        check("empty done_pulse", bus.done, 1);
        check("empty busy_dropped", bus.busy, 0);
        @(posedge clk); #1;
        check("empty done_single", bus.done, 0);
        check("empty busy_cycles", busy_cnt, 1);
        check("empty valid_cycles", valid_cnt, 0);

        // Reset in the middle of a scan with a pixel held
        ready_mode = 0;
        launch(t0);
        cyc = 0;
        while (got_q.size() < 5 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst five_pixels_seen", (got_q.size() >= 5), 1);
        ready_mode = 3;
        repeat (3) @(posedge clk);
        #1;
        check("midrst pixel_held", bus.pix_valid, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 0;
        build_model(t0);
        launch(t0);
        wait_done("after_rst");
        check("after_rst twelve_pixels", got_q.size(), 12);
        compare_seq("after_rst");

        // Start during scan must be ignored
        tb_alt = '{x0: 'h100, y0: 'h100, x1: 'h600, y1: 'h100, x2: 'h100, y2: 'h600,
                   xmin: 0, xmax: 7, ymin: 0, ymax: 7};
        build_model(t0);
        ready_mode = 1;
        launch(t0);
        repeat (6) @(posedge clk);
        #1;
        drive(tb_alt);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("ignore_start");
        compare_seq("ignore_start");
        ready_mode = 0;

        // Full-width rows end at the top coordinate without wrapping through zero
        tw = t0;
        tw.xmin = 0;
        tw.xmax = 255;
        tw.ymin = 2;
        tw.ymax = 3;
        build_model(tw);
        launch(tw);
        wait_done("wide_row");
        compare_seq("wide_row");

        // Random triangles, boxes and backpressure
        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            longint area;
            do begin
                tr.x0 = longint'($urandom_range(0, 2304)) - 256;
                tr.y0 = longint'($urandom_range(0, 2304)) - 256;
                tr.x1 = longint'($urandom_range(0, 2304)) - 256;
                tr.y1 = longint'($urandom_range(0, 2304)) - 256;
                tr.x2 = longint'($urandom_range(0, 2304)) - 256;
                tr.y2 = longint'($urandom_range(0, 2304)) - 256;
                area = (tr.x1 - tr.x0) * (tr.y2 - tr.y0) - (tr.x2 - tr.x0) * (tr.y1 - tr.y0);
            end while (area == 0);
            tr.xmin = int'($urandom_range(0, 3));
            tr.xmax = tr.xmin + int'($urandom_range(0, 6));
            tr.ymin = int'($urandom_range(0, 3));
            tr.ymax = tr.ymin + int'($urandom_range(0, 6));
            build_model(tr);
            launch(tr);
            wait_done($sformatf("rand%0d", k));
            compare_seq($sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
